// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and the
// parity helper used by the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } uart_state_e;

  localparam int UART_OVS_DEF       = 8;
  localparam int UART_DATA_BITS_DEF = 8;

  // 1 when data bits plus parity bit disagree with the selected parity sense
  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       pbit,
                                           input logic       odd);
    return (^data) ^ pbit ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so no false start bit is seen coming out of reset.
module uart_sync2 (
  input  logic sysclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // two-stage capture of the async input
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with a single
// holding register on a valid/ready output port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVS        = UART_OVS_DEF
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVS - 1);
  localparam logic [BW-1:0] BITN_LAST = BW'(DATA_BITS - 1);

  uart_state_e          state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [BW-1:0]        bitn_r, bitn_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 perr_r, perr_s;
  logic                 commit_s;
  logic                 rxs_s;

  uart_sync2 u_sync (
    .sysclk (sysclk),
    .rst    (rst),
    .d      (rxd),
    .q      (rxs_s)
  );

  // frame FSM, bit counters and shift register state
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bitn_r  <= '0;
      shift_r <= '0;
      perr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bitn_r  <= bitn_s;
      shift_r <= shift_s;
      perr_r  <= perr_s;
    end
  end

  // next-state logic; everything advances only on oversample ticks
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bitn_s   = bitn_r;
    shift_s  = shift_r;
    perr_s   = perr_r;
    commit_s = 1'b0;
    if (os_tick) begin
      case (state_r)
        IDLE: begin
          if (!rxs_s) begin
            state_s = START;
            cnt_s   = '0;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_s = '0;
            if (rxs_s) begin
              state_s = IDLE;
            end else begin
              state_s = DATA;
              bitn_s  = '0;
              perr_s  = 1'b0;
            end
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = '0;
            shift_s = {rxs_s, shift_r[DATA_BITS-1:1]};
            bitn_s  = bitn_r + 1'b1;
            if (bitn_r == BITN_LAST) begin
              state_s = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              state_s = DATA;
            end
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = '0;
            perr_s  = parity_mismatch(8'(shift_r), rxs_s, 1'(PARITY_ODD));
            state_s = STOP;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s    = '0;
            commit_s = 1'b1;
            // leaving at mid stop bit leaves half a bit to resync on the next start
            state_s  = rxs_s ? IDLE : WAIT_HI;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        WAIT_HI: begin
          if (rxs_s) begin
            state_s = IDLE;
          end else begin
            state_s = WAIT_HI;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // holding register, handshake, overrun pulse and busy flag
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      busy    <= (state_s != IDLE);
      if (commit_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_r;
          frame_err  <= ~rxs_s;
          parity_err <= (PARITY_EN != 0) ? perr_r : 1'b0;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
